// File: rtl/lcd_rx_decoder.sv
// lcd_rx_decoder: receive-side model of a 4-bit HD44780 bus.
//
// Samples LCD_D/LCD_E, assembles nibbles into bytes, decodes the command
// set and mirrors DDRAM into a 2 x LINE_LEN character buffer with a
// registered read port.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   LCD_D[4:0]  bit4 = RS, bits3:0 = DB7..DB4
//   LCD_E       enable strobe, data taken on its falling edge
//   rd_addr     {line, col[3:0]} buffer read address
//   rd_data     buffer byte, 1-cycle read latency
//   cmd_valid   1-cycle pulse per decoded RS=0 byte
//   char_valid  1-cycle pulse per decoded RS=1 byte
//   rx_byte     last decoded byte
//   cursor      DDRAM address {line, col[5:0]}
//   mode4       interface is in 4-bit mode
//   display_on  D bit of the last display-control command
//   busy        clear sweep in progress
//   ovr_err     sticky: strobe dropped while busy, or RS changed mid-byte
//
// Build option
//   LCD_RX_SYNC_EN  when defined, LCD_D/LCD_E pass through a 2-flop
//                   synchronizer first (adds 2 cycles to every latency).
module lcd_rx_decoder #(
  parameter int unsigned LINE_LEN = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] LCD_D,
  input  logic       LCD_E,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] rx_byte,
  output logic [6:0] cursor,
  output logic       mode4,
  output logic       display_on,
  output logic       busy,
  output logic       ovr_err
);

  localparam int unsigned BufLen = 2 * LINE_LEN;
  localparam int unsigned IdxW   = 5;
  localparam logic [5:0]      LineLenW = 6'(LINE_LEN);
  localparam logic [IdxW-1:0] LineOff  = IdxW'(LINE_LEN);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BufLen - 1);

  typedef enum logic [1:0] {StBus8, StHi, StLo} state_e;

  // ---------------------------------------------------------------------------
  // Input stage and strobe detection
  // ---------------------------------------------------------------------------
  logic [4:0] d_in;
  logic       e_in;

`ifdef LCD_RX_SYNC_EN
  logic [4:0] d_s1_q, d_s2_q;
  logic       e_s1_q, e_s2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_s1_q <= '0;
      d_s2_q <= '0;
      e_s1_q <= 1'b0;
      e_s2_q <= 1'b0;
    end else begin
      d_s1_q <= LCD_D;
      d_s2_q <= d_s1_q;
      e_s1_q <= LCD_E;
      e_s2_q <= e_s1_q;
    end
  end

  assign d_in = d_s2_q;
  assign e_in = e_s2_q;
`else
  assign d_in = LCD_D;
  assign e_in = LCD_E;
`endif

  logic       e_q;
  logic       strobe_q;
  logic [4:0] samp_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      e_q      <= 1'b0;
      strobe_q <= 1'b0;
      samp_q   <= '0;
    end else begin
      e_q      <= e_in;
      strobe_q <= e_q & ~e_in;
      samp_q   <= d_in;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      hi_nib_q;
  logic            hi_rs_q;
  logic [6:0]      cursor_q, cursor_d;
  logic            id_q, id_d;
  logic            disp_q, disp_d;
  logic            ovr_q;
  logic            cmd_vld_q, chr_vld_q;
  logic [7:0]      rx_byte_q;
  logic            busy_q;
  logic [IdxW-1:0] clr_cnt_q;
  logic [7:0]      mem_q [BufLen];

  logic       take, drop;
  logic [3:0] nib;
  logic       rs;

  // A strobe arriving during the clear sweep is discarded.
  assign take = strobe_q & ~busy_q;
  assign drop = strobe_q & busy_q;
  assign nib  = samp_q[3:0];
  assign rs   = samp_q[4];

  // Byte assembly outputs.
  logic       byte_vld;
  logic       byte_rs;
  logic [7:0] byte_val;
  logic       rs_mis;
  logic       is_cmd, is_char;

  assign is_cmd  = byte_vld & ~byte_rs;
  assign is_char = byte_vld & byte_rs;

  // FSM: state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StBus8;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (take) begin
      unique case (state_q)
        StBus8:  if (!rs && nib == 4'h2) state_d = StHi;
        StHi:    state_d = StLo;
        StLo:    state_d = StHi;
        default: state_d = StBus8;
      endcase
      // Function set with DL=1 drops back to 8-bit framing.
      if (is_cmd && byte_val[7:5] == 3'b001 && byte_val[4]) state_d = StBus8;
    end
  end

  // FSM: outputs (byte assembly).
  always_comb begin
    byte_vld = 1'b0;
    byte_rs  = 1'b0;
    byte_val = '0;
    rs_mis   = 1'b0;
    if (take) begin
      unique case (state_q)
        StBus8: begin
          // In 8-bit framing every byte is treated as a command; the
          // 0011/0010 init nibbles with RS=0 produce no byte.
          byte_val = {nib, 4'h0};
          byte_vld = rs || (nib != 4'h3 && nib != 4'h2);
        end
        StLo: begin
          byte_val = {hi_nib_q, nib};
          byte_rs  = hi_rs_q;
          byte_vld = 1'b1;
          rs_mis   = (rs != hi_rs_q);
        end
        default: ;
      endcase
    end
  end

  // Cursor step: cols 0..39 wrap across lines, cols 40..63 step in-field.
  function automatic logic [6:0] step_cursor(input logic [6:0] cur, input logic inc);
    logic       line;
    logic [5:0] col;
    line = cur[6];
    col  = cur[5:0];
    if (col > 6'd39) begin
      col = inc ? col + 6'd1 : col - 6'd1;
    end else if (inc) begin
      if (col == 6'd39) begin
        col  = 6'd0;
        line = ~line;
      end else begin
        col = col + 6'd1;
      end
    end else begin
      if (col == 6'd0) begin
        col  = 6'd39;
        line = ~line;
      end else begin
        col = col - 6'd1;
      end
    end
    return {line, col};
  endfunction

  // Command / data effects.
  logic            start_clr;
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;

  always_comb begin
    cursor_d  = cursor_q;
    id_d      = id_q;
    disp_d    = disp_q;
    start_clr = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cursor_q[6] ? LineOff + IdxW'(cursor_q[3:0]) : IdxW'(cursor_q[3:0]);
    if (is_cmd) begin
      // Highest set bit selects the command.
      casez (byte_val)
        8'b1???????: cursor_d = byte_val[6:0];
        8'b00001???: disp_d   = byte_val[2];
        8'b000001??: id_d     = byte_val[1];
        8'b0000001?: cursor_d = '0;
        8'b00000001: begin
          cursor_d  = '0;
          id_d      = 1'b1;
          start_clr = 1'b1;
        end
        default: ;
      endcase
    end else if (is_char) begin
      wr_en    = (cursor_q[5:0] < LineLenW);
      cursor_d = step_cursor(cursor_q, id_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_nib_q  <= '0;
      hi_rs_q   <= 1'b0;
      cursor_q  <= '0;
      id_q      <= 1'b1;
      disp_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cmd_vld_q <= 1'b0;
      chr_vld_q <= 1'b0;
      rx_byte_q <= '0;
      // Reset launches a clear sweep.
      busy_q    <= 1'b1;
      clr_cnt_q <= '0;
    end else begin
      cursor_q  <= cursor_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      cmd_vld_q <= is_cmd;
      chr_vld_q <= is_char;
      if (byte_vld) rx_byte_q <= byte_val;
      if (take && state_q == StHi) begin
        hi_nib_q <= nib;
        hi_rs_q  <= rs;
      end
      if (drop || rs_mis) ovr_q <= 1'b1;
      if (start_clr) begin
        busy_q    <= 1'b1;
        clr_cnt_q <= '0;
      end else if (busy_q) begin
        if (clr_cnt_q == LastIdx) busy_q <= 1'b0;
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy_q) begin
        mem_q[clr_cnt_q] <= 8'h20;
      end else if (wr_en) begin
        mem_q[wr_idx] <= byte_val;
      end
    end
  end

  logic [IdxW-1:0] rd_idx;
  assign rd_idx = rd_addr[4] ? LineOff + IdxW'(rd_addr[3:0]) : IdxW'(rd_addr[3:0]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data <= '0;
    end else if ({2'b00, rd_addr[3:0]} < LineLenW) begin
      rd_data <= mem_q[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  assign cmd_valid  = cmd_vld_q;
  assign char_valid = chr_vld_q;
  assign rx_byte    = rx_byte_q;
  assign cursor     = cursor_q;
  assign mode4      = (state_q != StBus8);
  assign display_on = disp_q;
  assign busy       = busy_q;
  assign ovr_err    = ovr_q;

endmodule

// File: tb/tb_lcd_rx_decoder.sv
// Self-checking bench for lcd_rx_decoder. Decoded bytes are predicted into
// exp_q as stimulus is driven and compared against bytes captured from the
// cmd_valid/char_valid pulses.
module tb_lcd_rx_decoder;

  localparam int unsigned LineLen = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] LCD_D;
  logic       LCD_E;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid;
  logic       char_valid;
  logic [7:0] rx_byte;
  logic [6:0] cursor;
  logic       mode4;
  logic       display_on;
  logic       busy;
  logic       ovr_err;

  lcd_rx_decoder #(.LINE_LEN(LineLen)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LCD_D      (LCD_D),
    .LCD_E      (LCD_E),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_valid  (cmd_valid),
    .char_valid (char_valid),
    .rx_byte    (rx_byte),
    .cursor     (cursor),
    .mode4      (mode4),
    .display_on (display_on),
    .busy       (busy),
    .ovr_err    (ovr_err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Entries are {is_char, byte}.
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  // One strobe; captures a decode pulse if one appears.
  task automatic send_nibble(input logic r, input logic [3:0] n);
    LCD_D = {r, n};
    LCD_E = 1'b1;
    repeat (2) @(negedge CLK);
    LCD_E = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (cmd_valid || char_valid) begin
        obs_q.push_back({char_valid, rx_byte});
        break;
      end
    end
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b, input logic predict);
    if (predict) exp_q.push_back({r, b});
    send_nibble(r, b[7:4]);
    send_nibble(r, b[3:0]);
  endtask

  task automatic read_buf(input logic [4:0] a, output logic [7:0] v);
    @(negedge CLK);
    rd_addr = a;
    @(posedge CLK);
    #1 v = rd_data;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL busy_timeout busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    int cnt;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({cmd_valid, char_valid, mode4, display_on, ovr_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want 00000",
               {cmd_valid, char_valid, mode4, display_on, ovr_err});
    end
    checks++;
    if (cursor !== 7'h00 || rx_byte !== 8'h00 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_values cursor=%h rx=%h rd=%h want 00 00 00", cursor, rx_byte, rd_data);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!busy) break;
      cnt++;
    end
    checks++;
    if (cnt != 2 * LineLen) begin
      failures++;
      $display("FAIL reset_sweep busy_cycles=%0d want %0d", cnt, 2 * LineLen);
    end
  endtask

  task automatic test_init();
    logic [8:0] e, o;
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    checks++;
    if (mode4 !== 1'b0) begin
      failures++;
      $display("FAIL init_mode4_early got=%b want 0", mode4);
    end
    send_nibble(1'b0, 4'h2);
    checks++;
    if (mode4 !== 1'b1) begin
      failures++;
      $display("FAIL init_mode4 got=%b want 1", mode4);
    end
    send_byte(1'b0, 8'h2C, 1'b1);
    checks++;
    if (mode4 !== 1'b1) begin
      failures++;
      $display("FAIL init_funcset_mode4 got=%b want 1", mode4);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL init_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL init_sb got=%h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL init_extra got=%0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_chars();
    logic [8:0] e, o;
    logic [7:0] v;
    send_byte(1'b1, 8'h48, 1'b1);
    send_byte(1'b1, 8'h69, 1'b1);
    checks++;
    if (cursor !== 7'h02) begin
      failures++;
      $display("FAIL chars_cursor got=%h want 02", cursor);
    end
    read_buf(5'd0, v);
    checks++;
    if (v !== 8'h48) begin
      failures++;
      $display("FAIL chars_buf0 got=%h want 48", v);
    end
    read_buf(5'd1, v);
    checks++;
    if (v !== 8'h69) begin
      failures++;
      $display("FAIL chars_buf1 got=%h want 69", v);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL chars_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL chars_sb got=%h want %h", o, e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_set_addr();
    logic [8:0] e, o;
    logic [7:0] v;
    send_byte(1'b0, 8'hC0, 1'b1);
    send_byte(1'b1, 8'h41, 1'b1);
    checks++;
    if (cursor !== 7'h41) begin
      failures++;
      $display("FAIL setaddr_cursor got=%h want 41", cursor);
    end
    read_buf(5'h10, v);
    checks++;
    if (v !== 8'h41) begin
      failures++;
      $display("FAIL setaddr_buf got=%h want 41", v);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL setaddr_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL setaddr_sb got=%h want %h", o, e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_clear();
    logic [8:0] e, o;
    logic [7:0] v;
    int cnt;
    send_byte(1'b0, 8'h0C, 1'b1);
    checks++;
    if (display_on !== 1'b1) begin
      failures++;
      $display("FAIL disp_on got=%b want 1", display_on);
    end
    send_byte(1'b0, 8'h01, 1'b1);
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!busy) break;
      cnt++;
    end
    checks++;
    if (cnt != 2 * LineLen) begin
      failures++;
      $display("FAIL clear_busy busy_cycles=%0d want %0d", cnt, 2 * LineLen);
    end
    checks++;
    if (cursor !== 7'h00) begin
      failures++;
      $display("FAIL clear_cursor got=%h want 00", cursor);
    end
    for (int a = 0; a < 32; a++) begin
      read_buf(5'(a), v);
      checks++;
      if (v !== 8'h20) begin
        failures++;
        $display("FAIL clear_buf addr=%0d got=%h want 20", a, v);
      end
    end
    // Second clear, then a whole byte strobed during the sweep.
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b1, 8'h45, 1'b0);
    checks++;
    if (ovr_err !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop_ovr got=%b want 1", ovr_err);
    end
    wait_idle();
    send_byte(1'b1, 8'h42, 1'b1);
    read_buf(5'd0, v);
    checks++;
    if (v !== 8'h42) begin
      failures++;
      $display("FAIL after_drop_buf got=%h want 42", v);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL clear_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL clear_sb got=%h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL clear_extra got=%0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_far_cursor();
    logic [8:0] e, o;
    logic [7:0] v;
    send_byte(1'b0, 8'hA7, 1'b1);
    send_byte(1'b1, 8'h5A, 1'b1);
    checks++;
    if (cursor !== 7'h40) begin
      failures++;
      $display("FAIL wrap0_cursor got=%h want 40", cursor);
    end
    read_buf(5'h10, v);
    checks++;
    if (v !== 8'h20) begin
      failures++;
      $display("FAIL wrap0_nowrite got=%h want 20", v);
    end
    send_byte(1'b0, 8'hE7, 1'b1);
    send_byte(1'b1, 8'h33, 1'b1);
    checks++;
    if (cursor !== 7'h00) begin
      failures++;
      $display("FAIL wrap1_cursor got=%h want 00", cursor);
    end
    read_buf(5'd0, v);
    checks++;
    if (v !== 8'h42) begin
      failures++;
      $display("FAIL wrap1_nowrite got=%h want 42", v);
    end
    // Decrement mode: {0,0} steps back to {1,39}.
    send_byte(1'b0, 8'h04, 1'b1);
    send_byte(1'b0, 8'h80, 1'b1);
    send_byte(1'b1, 8'h55, 1'b1);
    checks++;
    if (cursor !== 7'h67) begin
      failures++;
      $display("FAIL dec_cursor got=%h want 67", cursor);
    end
    read_buf(5'd0, v);
    checks++;
    if (v !== 8'h55) begin
      failures++;
      $display("FAIL dec_buf got=%h want 55", v);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL far_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL far_sb got=%h want %h", o, e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_midbyte();
    logic [8:0] e, o;
    logic [7:0] v;
    send_nibble(1'b0, 4'h8);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (mode4 !== 1'b0 || ovr_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state mode4=%b ovr=%b want 0 0", mode4, ovr_err);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    wait_idle();
    send_nibble(1'b0, 4'h8);
    exp_q.push_back({1'b0, 8'h80});
    checks++;
    if (rx_byte !== 8'h80 || mode4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_bus8 rx=%h mode4=%b want 80 0", rx_byte, mode4);
    end
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h2);
    // RS differs between nibbles: byte keeps the high nibble's RS.
    exp_q.push_back({1'b1, 8'h41});
    send_nibble(1'b1, 4'h4);
    send_nibble(1'b0, 4'h1);
    checks++;
    if (ovr_err !== 1'b1 || cursor !== 7'h01) begin
      failures++;
      $display("FAIL rs_mismatch ovr=%b cursor=%h want 1 01", ovr_err, cursor);
    end
    read_buf(5'd0, v);
    checks++;
    if (v !== 8'h41) begin
      failures++;
      $display("FAIL rs_mismatch_buf got=%h want 41", v);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL midrst_sb got=none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL midrst_sb got=%h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_extra got=%0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    RST     = 1'b1;
    LCD_D   = '0;
    LCD_E   = 1'b0;
    rd_addr = '0;
    test_reset();
    test_init();
    test_chars();
    test_set_addr();
    test_clear();
    test_far_cursor();
    test_reset_midbyte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_rx_decoder.md
# lcd_rx_decoder

Receive-side model of the 4-bit HD44780 bus driven by the LCD text/init engine. Samples `LCD_D`/`LCD_E`, assembles nibbles into bytes, interprets the command set and mirrors DDRAM into a 2-line character buffer with a read port. Used as the on-chip loopback checker and as the display model in system benches.

## Interface
- `LINE_LEN`, 16: visible columns per line, legal 1..16; buffer is 2×`LINE_LEN` bytes.
- `CLK`  in  1: system clock, all logic on rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `LCD_D`  in  5: bit4 = RS, bits3:0 = DB7..DB4.
- `LCD_E`  in  1: enable strobe, data latched on falling edge.
- `rd_addr`  in  5: {line, col[3:0]} buffer read address.
- `rd_data`  out  8: buffer byte, registered, 1-cycle read latency.
- `cmd_valid`  out  1: 1-cycle pulse, RS=0 byte decoded.
- `char_valid`  out  1: 1-cycle pulse, RS=1 byte decoded.
- `rx_byte`  out  8: last decoded byte, valid with either pulse.
- `cursor`  out  7: current DDRAM address {line, col[5:0]}.
- `mode4`  out  1: interface in 4-bit mode.
- `display_on`  out  1: D bit of last display-control command.
- `busy`  out  1: clear sweep in progress.
- `ovr_err`  out  1: sticky; strobe dropped while busy, or RS differed between nibbles.

## Operation
- Strobe = cycle where registered E was 1 and current E is 0; `LCD_D` sampled that cycle.
- States: `BUS8` → `HI` ↔ `LO`.
  - `BUS8`: each strobe is one byte, upper nibble = `LCD_D[3:0]`, lower = 0. Nibble 0011 with RS=0 → stay. Nibble 0010 with RS=0 → `mode4`=1, go `HI`. Other values → `cmd_valid` with byte {nibble,0000}, stay.
  - `HI`: store nibble and RS, go `LO`.
  - `LO`: byte = {hi, lo}, RS from high nibble; RS mismatch sets `ovr_err`. Decode, go `HI`.
- Command decode (RS=0, priority by highest set bit):
  - 0x01 clear: cursor=0, entry I/D=1, start clear sweep.
  - 0x02–0x03 home: cursor=0.
  - 0x04–0x07 entry mode: store I/D = bit1; S ignored.
  - 0x08–0x0F: `display_on` = bit2.
  - 0x10–0x1F: no effect.
  - 0x20–0x3F function set: DL (bit4)=1 → `mode4`=0, go `BUS8`.
  - 0x40–0x7F CGRAM: no effect.
  - 0x80–0xFF: cursor = byte[6:0].
- Data (RS=1): if col < `LINE_LEN`, write `buffer[line][col]`; cursor then steps by I/D.
- Cursor step: col 0..39 per line. Increment at {0,39} → {1,0}; at {1,39} → {0,0}. Decrement mirrors this. Cols 40..63, reachable only by set-address, step by ±1 within the 6-bit field, and writes there are discarded.
- Clear sweep: writes 0x20 to every buffer entry, one per cycle, `busy`=1 for 2×`LINE_LEN` cycles. Strobes during `busy` are dropped and set `ovr_err`.
- All command and data bytes pulse `cmd_valid`/`char_valid`, including no-effect commands.

## Timing
- Strobe detect: 1 cycle after E falls at the sampling stage.
- `cmd_valid`/`char_valid`/`rx_byte`/`cursor` update: 1 cycle after strobe detect.
- Buffer write visible on `rd_data` 2 cycles after strobe detect.
- Reset values: `rd_data`=0, pulses 0, `rx_byte`=0, `cursor`=0, `mode4`=0, `display_on`=0, `ovr_err`=0, I/D=1, state `BUS8`.
- Reset then launches a clear sweep: `busy`=1 on the first cycle after `RST` deasserts, for 2×`LINE_LEN` cycles.
- `RST` mid-byte discards the held high nibble.
- Clear issued while `busy`: dropped, sets `ovr_err`.

## Configuration
- `LCD_RX_SYNC_EN` defined: `LCD_D` and `LCD_E` pass through a 2-flop synchronizer before edge detection, adding 2 cycles to every latency above. Use this for asynchronous pins.
- `LCD_RX_SYNC_EN` undefined: inputs are used directly. Use this for same-clock loopback.

## Test plan
- After reset, strobe RS=0 nibbles 3,3,3,2 → `mode4`=1 after the 4th strobe. Then 2,C → `cmd_valid`, `rx_byte`=0x2C.
- In 4-bit mode, strobe RS=1 nibbles 4,8,6,9 → two `char_valid` pulses, buffer[0][0]=0x48, [0][1]=0x69, `cursor`=0x02.
- Command 0xC0, then data 0x41 → buffer[1][0]=0x41, `cursor`=0x41.
- Fill data, then command 0x01 → `busy` high 32 cycles, every `rd_data` reads 0x20, `cursor`=0. A strobe during `busy` is dropped and `ovr_err`=1.
- Command 0xA7, then data 0x5A → no buffer change, `cursor`=0x40. Command 0xE7, then data → `cursor`=0x00.
- `RST` asserted after one high nibble → `mode4`=0, state `BUS8`. Next strobe nibble 0x8 with RS=0 decodes as `cmd_valid`, `rx_byte`=0x80.
